// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side bundle between the pipeline and the forwarding/hazard controller.
//   master : the CPU pipeline. It drives the decoded ID instruction plus the
//            flush and mem_wait controls, and receives the stall and forward selects.
//   slave  : fwd_hazard_ctrl.
// Operand i of id_rs sits at [i*REG_ADDR_W +: REG_ADDR_W].
// Operand i of each fwd_* vector sits at [2*i +: 2].
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int CNT_W      = 16
);
  logic                         id_valid;
  logic [NUM_RD*REG_ADDR_W-1:0] id_rs;
  logic [NUM_RD-1:0]            id_rs_used;
  logic [REG_ADDR_W-1:0]        id_rd;
  logic                         id_reg_write;
  logic                         id_mem_read;
  logic                         id_branch;
  logic                         flush_id;
  logic                         mem_wait;
  logic                         stall_id;
  logic [NUM_RD*2-1:0]          fwd_ex;
  logic [NUM_RD*2-1:0]          fwd_id;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
           id_branch, flush_id, mem_wait,
    input  stall_id, fwd_ex, fwd_id, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_mem_read,
           id_branch, flush_id, mem_wait,
    output stall_id, fwd_ex, fwd_id, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// The controller keeps a shadow copy of the EX/MEM/WB destination tags, which
// it fills from the ID stage. From these tags it produces:
//   - the EX operand forward selects,
//   - the ID branch-comparator forward selects,
//   - the ID stall,
//   - a saturating count of hazard stall cycles.
// Ports: clk, rst_n (async, active low), bus (fwd_hazard_ctrl_if.slave).
// Forward select encoding: 00 regfile, 01 EX/MEM, 10 MEM/WB.

// Per-operand hazard detect and forward select.
// Inputs:  ID and EX source tags, stage tags and their live flags.
// Outputs: haz, fwd_ex, and the ungated fwd_id.
module fwd_hazard_opnd #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_used,
  input  logic                  id_branch,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic                  ex_used,
  input  logic                  ex_live,
  input  logic                  ex_mr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_live,
  input  logic                  mem_mr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_live,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  haz,
  output logic [1:0]            fwd_ex,
  output logic [1:0]            fwd_id
);
  logic id_ex_m, id_mem_m, id_wb_m, ex_mem_m, ex_wb_m;

  always_comb begin
    id_ex_m  = ex_live  && (ex_rd  == id_rs);
    id_mem_m = mem_live && (mem_rd == id_rs);
    id_wb_m  = wb_live  && (wb_rd  == id_rs);
    ex_mem_m = mem_live && (mem_rd == ex_rs);
    ex_wb_m  = wb_live  && (wb_rd  == ex_rs);

    // Three stall sources are checked: a load-use hazard, a branch on an ALU
    // result still in EX, and a branch on a load still in MEM.
    haz = id_used && ((ex_mr && id_ex_m) ||
                      (id_branch && id_ex_m) ||
                      (id_branch && mem_mr && id_mem_m));

    // MEM is checked before WB, so the newest producer wins.
    fwd_ex = 2'b00;
    if (ex_used && ex_mem_m && !mem_mr) fwd_ex = 2'b01;
    else if (ex_used && ex_wb_m)        fwd_ex = 2'b10;

    fwd_id = 2'b00;
    if (id_mem_m && !mem_mr) fwd_id = 2'b01;
    else if (id_wb_m)        fwd_id = 2'b10;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_ctrl_if.slave   bus
);
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
    logic                  mr;
  } stage_t;

  // WB never needs the load flag, so it is not kept there.
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
  } wb_t;

  stage_t                       ex_q, ex_d, mem_q, mem_d;
  wb_t                          wb_q, wb_d;
  logic [NUM_RD*REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [NUM_RD-1:0]            ex_used_q, ex_used_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic                         ex_live, mem_live, wb_live, hazard;
  logic [NUM_RD-1:0]            haz_op;
  logic [NUM_RD-1:0][1:0]       fwd_ex_w, fwd_id_w;

  // A write to x0 is never live, so it is never forwarded and never stalled on.
  assign ex_live  = ex_q.v  && ex_q.rw  && (ex_q.rd  != '0);
  assign mem_live = mem_q.v && mem_q.rw && (mem_q.rd != '0);
  assign wb_live  = wb_q.v  && wb_q.rw  && (wb_q.rd  != '0);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_op
    fwd_hazard_opnd #(.REG_ADDR_W(REG_ADDR_W)) u_opnd (
      .id_rs     (bus.id_rs[g*REG_ADDR_W +: REG_ADDR_W]),
      .id_used   (bus.id_rs_used[g]),
      .id_branch (bus.id_branch),
      .ex_rs     (ex_rs_q[g*REG_ADDR_W +: REG_ADDR_W]),
      .ex_used   (ex_used_q[g]),
      .ex_live   (ex_live),
      .ex_mr     (ex_q.mr),
      .ex_rd     (ex_q.rd),
      .mem_live  (mem_live),
      .mem_mr    (mem_q.mr),
      .mem_rd    (mem_q.rd),
      .wb_live   (wb_live),
      .wb_rd     (wb_q.rd),
      .haz       (haz_op[g]),
      .fwd_ex    (fwd_ex_w[g]),
      .fwd_id    (fwd_id_w[g])
    );

    // The load-use stall guarantees that a real EX consumer never finds its
    // producer as an unfinished load in MEM.
    a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
      !(ex_q.v && ex_used_q[g] && mem_live && mem_q.mr &&
        (mem_q.rd == ex_rs_q[g*REG_ADDR_W +: REG_ADDR_W])));
  end

  // Several sources, or several operands, still make one stall per cycle.
  assign hazard        = bus.id_valid && (|haz_op);
  assign bus.stall_id  = hazard || bus.mem_wait;
  assign bus.fwd_ex    = fwd_ex_w;
  assign bus.fwd_id    = (bus.id_branch && bus.id_valid && !hazard) ? fwd_id_w : '0;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    ex_rs_d     = ex_rs_q;
    ex_used_d   = ex_used_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.mem_wait) begin
      wb_d  = '{v: mem_q.v, rd: mem_q.rd, rw: mem_q.rw};
      mem_d = ex_q;
      if (hazard) begin
        // The bubble wins over flush_id; squashing the instruction is the CPU's concern.
        ex_d      = '0;
        ex_rs_d   = '0;
        ex_used_d = '0;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        ex_d      = '{v: bus.id_valid && !bus.flush_id, rd: bus.id_rd,
                      rw: bus.id_reg_write, mr: bus.id_mem_read};
        ex_rs_d   = bus.id_rs;
        ex_used_d = bus.id_rs_used;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      ex_rs_q     <= '0;
      ex_used_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      ex_rs_q     <= ex_rs_d;
      ex_used_q   <= ex_used_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl.
//   dut_a: the default build (NUM_RD=2, CNT_W=16).
//   dut_b: a NUM_RD=3, CNT_W=2 build used for the saturation case.
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after that.
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_RD(2), .CNT_W(16)) ia ();
  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_RD(3), .CNT_W(2))  ib ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_RD(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_RD(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // The A-side ID instruction. Its sources are packed as {rs1, rs0}.
  task automatic id_a(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic br);
    ia.id_valid = v; ia.id_rs = {rs1, rs0}; ia.id_rs_used = used;
    ia.id_rd = rd; ia.id_reg_write = rw; ia.id_mem_read = mr;
    ia.id_branch = br; ia.flush_id = 1'b0;
  endtask

  task automatic nop_a();
    id_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic id_b(input logic v, input logic [14:0] rs, input logic [2:0] used,
                      input logic [4:0] rd, input logic rw, input logic mr);
    ib.id_valid = v; ib.id_rs = rs; ib.id_rs_used = used;
    ib.id_rd = rd; ib.id_reg_write = rw; ib.id_mem_read = mr;
    ib.id_branch = 1'b0; ib.flush_id = 1'b0;
  endtask

  initial begin
    nop_a();
    ia.mem_wait = 1'b0;
    id_b(1'b0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    ib.mem_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_stall", ia.stall_id, 0);
    chk("rst_fwd_ex", ia.fwd_ex, 0);
    chk("rst_fwd_id", ia.fwd_id, 0);
    chk("rst_cnt", ia.stall_cnt, 0);

    // Load-use: lw x5 followed by add x6,x5,x7.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1, 0); #1;
    chk("lw_nostall", ia.stall_id, 0);
    adv();
    id_a(1, 5'd5, 5'd7, 2'b11, 5'd6, 1, 0, 0); #1;
    chk("lu_stall", ia.stall_id, 1);
    adv();
    chk("lu_release", ia.stall_id, 0);
    chk("lu_cnt", ia.stall_cnt, 1);
    adv(); nop_a(); #1;
    chk("lu_fwd_ex", ia.fwd_ex, 4'b0010);

    // Branch on an ALU result still in EX.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd3, 1, 0, 0);
    adv();
    id_a(1, 5'd3, 5'd3, 2'b11, 5'd0, 0, 0, 1); #1;
    chk("br_alu_stall", ia.stall_id, 1);
    chk("br_alu_fwdid_gated", ia.fwd_id, 0);
    adv();
    chk("br_alu_release", ia.stall_id, 0);
    chk("br_alu_fwd_id", ia.fwd_id, 4'b0101);
    chk("br_alu_cnt", ia.stall_cnt, 2);
    adv(); nop_a();

    // addi x3, nop, beq: the producer is in MEM, so no stall is needed.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd3, 1, 0, 0);
    adv(); nop_a();
    adv(); id_a(1, 5'd3, 5'd3, 2'b11, 5'd0, 0, 0, 1); #1;
    chk("br_gap_nostall", ia.stall_id, 0);
    chk("br_gap_fwd_id", ia.fwd_id, 4'b0101);
    chk("br_gap_cnt", ia.stall_cnt, 2);
    adv(); nop_a();

    // lw x3, nop, beq: the load is in MEM, so the branch stalls once and then reads WB.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd3, 1, 1, 0);
    adv(); nop_a();
    adv(); id_a(1, 5'd3, 5'd3, 2'b11, 5'd0, 0, 0, 1); #1;
    chk("br_ld_stall", ia.stall_id, 1);
    adv();
    chk("br_ld_release", ia.stall_id, 0);
    chk("br_ld_fwd_id", ia.fwd_id, 4'b1010);
    chk("br_ld_cnt", ia.stall_cnt, 3);
    adv(); nop_a();

    // The newer producer in MEM beats the older one in WB.
    id_a(1, 5'd1, 5'd1, 2'b11, 5'd2, 1, 0, 0);
    adv();
    adv(); id_a(1, 5'd2, 5'd2, 2'b11, 5'd4, 1, 0, 0); #1;
    chk("prio_nostall", ia.stall_id, 0);
    adv(); nop_a(); #1;
    chk("prio_fwd_ex", ia.fwd_ex, 4'b0101);

    // Writes to x0 are never forwarded.
    id_a(1, 5'd1, 5'd1, 2'b11, 5'd0, 1, 0, 0);
    adv();
    adv(); id_a(1, 5'd0, 5'd0, 2'b11, 5'd4, 1, 0, 0); #1;
    chk("x0_nostall", ia.stall_id, 0);
    adv(); nop_a(); #1;
    chk("x0_fwd_ex", ia.fwd_ex, 0);

    // A flushed load never reaches EX, so its consumer does not stall.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd9, 1, 1, 0); ia.flush_id = 1'b1;
    adv();
    id_a(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 0, 0); #1;
    chk("flush_nostall", ia.stall_id, 0);
    adv(); nop_a();
    adv();

    // mem_wait freezes the pipeline while a load-use pair is pending.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1, 0);
    adv();
    id_a(1, 5'd5, 5'd7, 2'b11, 5'd6, 1, 0, 0); ia.mem_wait = 1'b1; #1;
    chk("mw_stall0", ia.stall_id, 1);
    for (int k = 0; k < 3; k++) begin
      adv();
      chk("mw_stall", ia.stall_id, 1);
      chk("mw_cnt_hold", ia.stall_cnt, 3);
    end
    ia.mem_wait = 1'b0; #1;
    chk("mw_frozen_hazard", ia.stall_id, 1);
    adv();
    chk("mw_one_stall", ia.stall_id, 0);
    chk("mw_cnt", ia.stall_cnt, 4);
    adv(); nop_a(); #1;
    chk("mw_fwd_ex", ia.fwd_ex, 4'b0010);

    // dut_b: five load-use pairs on operand 2. The 2-bit counter saturates at 3.
    for (int p = 0; p < 5; p++) begin
      logic [4:0] r;
      r = 5'(10 + p);
      id_b(1, {5'd0, 5'd0, 5'd1}, 3'b001, r, 1, 1);
      adv();
      id_b(1, {r, 5'd0, 5'd0}, 3'b100, 5'd20, 1, 0); #1;
      chk("b_stall", ib.stall_id, 1);
      adv();
      chk("b_release", ib.stall_id, 0);
      adv(); id_b(0, 15'd0, 3'b000, 5'd0, 0, 0); #1;
      chk("b_fwd_ex", ib.fwd_ex, 6'b100000);
      chk("b_cnt", ib.stall_cnt, (p < 3) ? p + 1 : 3);
      adv();
    end

    // Reset arrives asynchronously while a live load sits in EX.
    id_a(1, 5'd1, 5'd0, 2'b01, 5'd5, 1, 1, 0);
    adv();
    id_a(1, 5'd5, 5'd7, 2'b11, 5'd6, 1, 0, 0); #1;
    chk("pre_rst_stall", ia.stall_id, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall", ia.stall_id, 0);
    chk("arst_fwd_ex", ia.fwd_ex, 0);
    chk("arst_fwd_id", ia.fwd_id, 0);
    chk("arst_cnt", ia.stall_cnt, 0);
    chk("arst_cnt_b", ib.stall_cnt, 0);
    #1 rst_n = 1'b1;
    adv(); #1;
    chk("post_rst_nostall", ia.stall_id, 0);
    chk("post_rst_cnt", ia.stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
